// File: rtl/riscv_core_hazard_pkg.sv
// Shared types and constants for the RV64IMAC pipeline hazard controller.
// Holds the trap FSM encoding, the forward-select base code and register-index sizing.
package riscv_core_hazard_pkg;

    localparam int REG_AW      = 5;
    localparam int NUM_REGS    = 1 << REG_AW;
    localparam int SB_CNT_W    = 4;
    localparam int FWD_REGFILE = 0;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        HZ_IDLE  = 2'd0,
        HZ_DRAIN = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/riscv_core_hazard_scoreboard.sv
// Register scoreboard for out-of-band long-latency writers (divide, missed loads).
// Tracks one pending bit per architectural register and the count of writes in flight.
module riscv_core_hazard_scoreboard
    import riscv_core_hazard_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  reg_idx_t rs1_id_i,
    input  reg_idx_t rs2_id_i,
    input  reg_idx_t rd_id_i,
    input  logic     issue_long_i,
    input  logic     issue_i,
    input  logic     lw_done_i,
    input  reg_idx_t lw_rd_i,
    input  logic     clear_i,
    output logic     sb_hit_o,
    output logic     full_o,
    output logic     empty_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [SB_CNT_W-1:0] count_q, count_d;
    logic                retire;
    logic                collide;

    assign sb_hit_o = pending_q[rs1_id_i] | pending_q[rs2_id_i] | pending_q[rd_id_i];
    assign full_o   = (count_q == SB_CNT_W'(MAX_OUT)) && issue_long_i;
    assign empty_o  = (count_q == '0);

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        retire    = lw_done_i && (lw_rd_i != '0) && pending_q[lw_rd_i];
        collide   = issue_i && lw_done_i && (lw_rd_i == rd_id_i);

        if (clear_i) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (retire) pending_d[lw_rd_i] = 1'b0;
            if (issue_i) pending_d[rd_id_i] = 1'b1;

            // A same-register issue/retire pair leaves the entry live and the count untouched.
            if (collide) begin
                count_d = count_q;
            end else if (issue_i && !retire) begin
                count_d = count_q + 1'b1;
            end else if (retire && !issue_i && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: the pending vector is control state, not storage, so it is reset like any other flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/riscv_core_hazard_ctrl.sv
// Pipeline hazard controller: multi-stage forwarding, load-use and scoreboard interlocks,
// and a trap drain/flush state machine driving every stage's stall and flush enables.
module riscv_core_hazard_ctrl
    import riscv_core_hazard_pkg::*;
#(
    parameter  int NUM_FWD       = 2,
    parameter  int MAX_OUT       = 4,
    parameter  int DRAIN_TIMEOUT = 64,
    localparam int FWD_W         = $clog2(NUM_FWD + 1)
) (
    input  logic                      i_hazard_ctrl_clk,
    input  logic                      i_hazard_ctrl_rst_n,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_rs1_id,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_rs2_id,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_rd_id,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_rs1_ex,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_rs2_ex,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_rd_ex,
    input  logic [NUM_FWD*REG_AW-1:0] i_hazard_ctrl_fwd_rd,
    input  logic [NUM_FWD-1:0]        i_hazard_ctrl_fwd_we,
    input  logic                      i_hazard_ctrl_load_ex,
    input  logic                      i_hazard_ctrl_pcsrc_ex,
    input  logic                      i_hazard_ctrl_issue_long,
    input  logic                      i_hazard_ctrl_lw_done,
    input  logic [REG_AW-1:0]         i_hazard_ctrl_lw_rd,
    input  logic                      i_hazard_ctrl_icache_stall,
    input  logic                      i_hazard_ctrl_dcache_stall,
    input  logic                      i_hazard_ctrl_trap_req,
    input  logic                      i_hazard_ctrl_mdivby0,
    input  logic                      i_hazard_ctrl_mof,
    output logic [FWD_W-1:0]          o_hazard_ctrl_fwda_ex,
    output logic [FWD_W-1:0]          o_hazard_ctrl_fwdb_ex,
    output logic                      o_hazard_ctrl_stall_if,
    output logic                      o_hazard_ctrl_stall_id,
    output logic                      o_hazard_ctrl_stall_ex,
    output logic                      o_hazard_ctrl_stall_mem,
    output logic                      o_hazard_ctrl_stall_wb,
    output logic                      o_hazard_ctrl_flush_id,
    output logic                      o_hazard_ctrl_flush_ex,
    output logic                      o_hazard_ctrl_flush_mem,
    output logic                      o_hazard_ctrl_flush_wb,
    output logic                      o_hazard_ctrl_trap_ack,
    output logic                      o_hazard_ctrl_timeout,
    output logic                      o_hazard_ctrl_exception
);

    localparam int DRAIN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    hz_state_e          state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               timeout_q, timeout_d;
    logic               fault_q, exc_q, out_en_q;

    logic               luse, sb_hit, sb_full, sb_empty, sb_clear, issue, fault;
    logic [FWD_W-1:0]   fwda, fwdb;
    logic               stall_if, stall_id, flush_id, flush_ex, flush_mem, flush_wb, trap_ack;

    // Lowest stage index is the youngest producer, so scan downward and let it overwrite.
    always_comb begin
        fwda = FWD_W'(FWD_REGFILE);
        fwdb = FWD_W'(FWD_REGFILE);
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_hazard_ctrl_fwd_we[i] && (i_hazard_ctrl_rs1_ex != '0) &&
                (i_hazard_ctrl_fwd_rd[i*REG_AW +: REG_AW] == i_hazard_ctrl_rs1_ex))
                fwda = FWD_W'(i + 1);
            if (i_hazard_ctrl_fwd_we[i] && (i_hazard_ctrl_rs2_ex != '0) &&
                (i_hazard_ctrl_fwd_rd[i*REG_AW +: REG_AW] == i_hazard_ctrl_rs2_ex))
                fwdb = FWD_W'(i + 1);
        end
    end

    assign luse = i_hazard_ctrl_load_ex && (i_hazard_ctrl_rd_ex != '0) &&
                  ((i_hazard_ctrl_rs1_id == i_hazard_ctrl_rd_ex) ||
                   (i_hazard_ctrl_rs2_id == i_hazard_ctrl_rd_ex));

    assign issue = i_hazard_ctrl_issue_long && (i_hazard_ctrl_rd_id != '0) &&
                   !stall_id && (state_q == HZ_IDLE);

    riscv_core_hazard_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk_i        (i_hazard_ctrl_clk),
        .rst_n_i      (i_hazard_ctrl_rst_n),
        .rs1_id_i     (i_hazard_ctrl_rs1_id),
        .rs2_id_i     (i_hazard_ctrl_rs2_id),
        .rd_id_i      (i_hazard_ctrl_rd_id),
        .issue_long_i (i_hazard_ctrl_issue_long),
        .issue_i      (issue),
        .lw_done_i    (i_hazard_ctrl_lw_done),
        .lw_rd_i      (i_hazard_ctrl_lw_rd),
        .clear_i      (sb_clear),
        .sb_hit_o     (sb_hit),
        .full_o       (sb_full),
        .empty_o      (sb_empty)
    );

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        sb_clear  = 1'b0;
        stall_if  = luse | sb_hit | sb_full | i_hazard_ctrl_icache_stall |
                    i_hazard_ctrl_dcache_stall | (state_q != HZ_IDLE);
        stall_id  = luse | sb_hit | sb_full | i_hazard_ctrl_dcache_stall | (state_q == HZ_DRAIN);
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;
        trap_ack  = 1'b0;

        unique case (state_q)
            HZ_IDLE: begin
                flush_id = i_hazard_ctrl_pcsrc_ex;
                flush_ex = i_hazard_ctrl_pcsrc_ex | luse |
                           ((sb_hit | sb_full) && !i_hazard_ctrl_dcache_stall);
                if (i_hazard_ctrl_trap_req) begin
                    state_d = HZ_DRAIN;
                    drain_d = '0;
                end
            end
            HZ_DRAIN: begin
                // ID is held while the back end keeps moving, so EX takes a bubble.
                flush_ex = !i_hazard_ctrl_dcache_stall;
                if (sb_empty) begin
                    state_d = HZ_FLUSH;
                end else if (drain_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d   = HZ_FLUSH;
                    timeout_d = 1'b1;
                    sb_clear  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            HZ_FLUSH: begin
                flush_id  = 1'b1;
                flush_ex  = 1'b1;
                flush_mem = 1'b1;
                flush_wb  = 1'b1;
                trap_ack  = 1'b1;
                state_d   = HZ_IDLE;
            end
            default: state_d = HZ_IDLE;
        endcase
    end

    assign fault = i_hazard_ctrl_mdivby0 | i_hazard_ctrl_mof;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_hazard_ctrl_clk or negedge i_hazard_ctrl_rst_n) begin
        if (!i_hazard_ctrl_rst_n) begin
            state_q   <= HZ_IDLE;
            drain_q   <= '0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
            exc_q     <= 1'b0;
            out_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            fault_q   <= fault;
            exc_q     <= fault & ~fault_q;
            out_en_q  <= 1'b1;
        end
    end

    // Control outputs are held low from reset assertion until the first clock after release.
    assign o_hazard_ctrl_fwda_ex   = out_en_q ? fwda : '0;
    assign o_hazard_ctrl_fwdb_ex   = out_en_q ? fwdb : '0;
    assign o_hazard_ctrl_stall_if  = out_en_q & stall_if;
    assign o_hazard_ctrl_stall_id  = out_en_q & stall_id;
    assign o_hazard_ctrl_stall_ex  = out_en_q & i_hazard_ctrl_dcache_stall;
    assign o_hazard_ctrl_stall_mem = out_en_q & i_hazard_ctrl_dcache_stall;
    assign o_hazard_ctrl_stall_wb  = 1'b0;
    assign o_hazard_ctrl_flush_id  = out_en_q & flush_id;
    assign o_hazard_ctrl_flush_ex  = out_en_q & flush_ex;
    assign o_hazard_ctrl_flush_mem = out_en_q & flush_mem;
    assign o_hazard_ctrl_flush_wb  = out_en_q & flush_wb;
    assign o_hazard_ctrl_trap_ack  = out_en_q & trap_ack;
    assign o_hazard_ctrl_timeout   = timeout_q;
    assign o_hazard_ctrl_exception = exc_q;

endmodule
